// File: rtl/cylon_pkg.sv
// Shared constants for the cylon display: mode encodings, default mode count,
// and the demo-sequencer state type used by the front-panel controller.
package cylon_pkg;

    // Display mode encodings understood by the cylon display engine
    localparam int MODE_CYLON  = 0;
    localparam int MODE_R_TO_L = 1;
    localparam int MODE_L_TO_R = 2;
    localparam int MODE_COUNT  = 3;

    // Default number of selectable display modes
    localparam int CYLON_NUM_MODES = 4;

    // Demo sequencer: idle (manual mode selection) or auto-advancing
    typedef enum logic {
        DEMO_IDLE = 1'b0,
        DEMO_RUN  = 1'b1
    } demo_state_e;

endpackage

// File: rtl/button_debounce.sv
// Conditions one raw asynchronous push-button: 2-flop synchroniser, a
// stability counter that accepts a level change only after DEBOUNCE_CYCLES
// consecutive differing samples, and a one-cycle pulse on each accepted press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             press_q;

    // Stability counter: any sample matching the accepted level restarts it
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser, counter, accepted level and registered rising-edge pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/cylon_mode_ctrl.sv
// Front-panel controller: debounces the mode buttons and the demo toggle,
// arbitrates presses (lowest mode index wins) and runs a demo sequencer that
// steps through every mode on a fixed timer.
module cylon_mode_ctrl
    import cylon_pkg::*;
#(
    parameter int NUM_MODES       = CYLON_NUM_MODES,
    parameter int MODE_WIDTH      = $clog2(NUM_MODES),
    parameter int RESET_MODE      = MODE_CYLON,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DEMO_CYCLES     = 400_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_MODES-1:0]  btn,
    input  logic                  btn_demo,
    output logic [MODE_WIDTH-1:0] mode,
    output logic                  mode_strobe,
    output logic                  demo_active
);

    localparam int                    TMR_W      = $clog2(DEMO_CYCLES);
    localparam logic [TMR_W-1:0]      TMR_LAST   = TMR_W'(DEMO_CYCLES - 1);
    localparam logic [MODE_WIDTH-1:0] MODE_LAST  = MODE_WIDTH'(NUM_MODES - 1);
    localparam logic [MODE_WIDTH-1:0] MODE_RESET = MODE_WIDTH'(RESET_MODE);

    // Index NUM_MODES is the demo toggle; the rest are the mode buttons
    logic [NUM_MODES:0] raw_all;
    logic [NUM_MODES:0] press_all;
    logic [NUM_MODES:0] unused_level;

    assign raw_all = {btn_demo, btn};

    for (genvar g = 0; g <= NUM_MODES; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw_all[g]),
            .level   (unused_level[g]),
            .press   (press_all[g])
        );
    end

    logic                  mode_hit;
    logic [MODE_WIDTH-1:0] mode_sel;
    logic                  demo_press;

    assign demo_press = press_all[NUM_MODES];

    // Priority pick: scanning downward lets the lowest pressed index win
    always_comb begin
        mode_hit = 1'b0;
        mode_sel = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (press_all[i]) begin
                mode_hit = 1'b1;
                mode_sel = MODE_WIDTH'(i);
            end
        end
    end

    demo_state_e           state_q, state_d;
    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  strobe_q, strobe_d;

    // Next state: mode press beats demo press beats timer expiry
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tmr_d   = tmr_q;
        if (mode_hit) begin
            mode_d  = mode_sel;
            state_d = DEMO_IDLE;
            tmr_d   = '0;
        end else if (demo_press) begin
            state_d = (state_q == DEMO_IDLE) ? DEMO_RUN : DEMO_IDLE;
            tmr_d   = '0;
        end else if (state_q == DEMO_RUN) begin
            if (tmr_q == TMR_LAST) begin
                tmr_d  = '0;
                mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_WIDTH'(1);
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
        strobe_d = (mode_d != mode_q);
    end

    // Mode register, demo state, timer and change strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= DEMO_IDLE;
            mode_q   <= MODE_RESET;
            tmr_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            tmr_q    <= tmr_d;
            strobe_q <= strobe_d;
        end
    end

    assign mode        = mode_q;
    assign mode_strobe = strobe_q;
    assign demo_active = (state_q == DEMO_RUN);

endmodule

// File: tb/tb_cylon_mode_ctrl.sv
// Bench for cylon_mode_ctrl: directed scenarios plus random button activity,
// checked every cycle against a reference model through a scoreboard queue.
module tb_cylon_mode_ctrl;

    localparam int NM = 4;
    localparam int MW = 2;
    localparam int DB = 4;
    localparam int DM = 20;
    localparam int NB = NM + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NM-1:0] btn;
    logic          btn_demo;
    logic [MW-1:0] mode;
    logic          mode_strobe;
    logic          demo_active;

    always #5 clk = ~clk;

    cylon_mode_ctrl #(
        .NUM_MODES       (NM),
        .MODE_WIDTH      (MW),
        .RESET_MODE      (0),
        .DEBOUNCE_CYCLES (DB),
        .DEMO_CYCLES     (DM)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn         (btn),
        .btn_demo    (btn_demo),
        .mode        (mode),
        .mode_strobe (mode_strobe),
        .demo_active (demo_active)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int mode;
        bit strobe;
        bit demo;
    } exp_t;

    exp_t sbq[$];

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raw level reaches the debouncer two edges late; a level
    // is accepted once the last DB synchronised samples all differ from it; a
    // press acts two edges after acceptance; the demo advances DM edges after
    // its last restart.
    bit m_dly  [NB][2];
    bit m_win  [NB][DB];
    bit m_acc  [NB];
    bit m_rise [NB][2];
    int m_mode;
    bit m_demo;
    int m_restart;
    int edge_n = 0;

    always @(posedge clk) begin
        exp_t e;
        bit   raw_now, s2, differ_all, rise, dp;
        int   mp, prev_mode;
        edge_n++;
        if (!reset_n) begin
            for (int b = 0; b < NB; b++) begin
                m_dly[b][0]  = 1'b0;
                m_dly[b][1]  = 1'b0;
                m_acc[b]     = 1'b0;
                m_rise[b][0] = 1'b0;
                m_rise[b][1] = 1'b0;
                for (int j = 0; j < DB; j++) m_win[b][j] = 1'b0;
            end
            m_mode    = 0;
            m_demo    = 1'b0;
            m_restart = edge_n;
            e.mode    = 0;
            e.strobe  = 1'b0;
            e.demo    = 1'b0;
        end else begin
            prev_mode = m_mode;
            mp = -1;
            for (int b = NM - 1; b >= 0; b--) if (m_rise[b][1]) mp = b;
            dp = m_rise[NM][1];
            if (mp >= 0) begin
                m_mode    = mp;
                m_demo    = 1'b0;
                m_restart = edge_n;
            end else if (dp) begin
                m_demo    = !m_demo;
                m_restart = edge_n;
            end else if (m_demo && (edge_n - m_restart == DM)) begin
                m_mode    = (m_mode + 1) % NM;
                m_restart = edge_n;
            end
            for (int b = 0; b < NB; b++) begin
                raw_now     = (b < NM) ? btn[b] : btn_demo;
                s2          = m_dly[b][1];
                m_dly[b][1] = m_dly[b][0];
                m_dly[b][0] = raw_now;
                for (int j = DB - 1; j > 0; j--) m_win[b][j] = m_win[b][j-1];
                m_win[b][0] = s2;
                differ_all = 1'b1;
                for (int j = 0; j < DB; j++) if (m_win[b][j] == m_acc[b]) differ_all = 1'b0;
                rise = differ_all && !m_acc[b];
                if (differ_all) m_acc[b] = !m_acc[b];
                m_rise[b][1] = m_rise[b][0];
                m_rise[b][0] = rise;
            end
            e.mode   = m_mode;
            e.strobe = (m_mode != prev_mode);
            e.demo   = m_demo;
        end
        sbq.push_back(e);
    end

    // Monitor: outputs are presented every cycle; compare on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty: got no expectation for DUT output (t=%0t)", $time);
        end else begin
            e = sbq.pop_front();
            check_val("sb_mode",   int'(mode),        e.mode);
            check_val("sb_strobe", int'(mode_strobe), int'(e.strobe));
            check_val("sb_demo",   int'(demo_active), int'(e.demo));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input int idx);
        btn[idx] = 1'b1;
        step(10);
        btn[idx] = 1'b0;
        step(10);
    endtask

    int rst_left;

    initial begin
        reset_n  = 1'b0;
        btn      = '0;
        btn_demo = 1'b0;

        // Reset held for three cycles
        step(3);
        check_val("rst_mode",   int'(mode),        0);
        check_val("rst_demo",   int'(demo_active), 0);
        check_val("rst_strobe", int'(mode_strobe), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check_val("idle_strobe", int'(mode_strobe), 0);
        end

        // Three-cycle glitch is rejected
        btn[2] = 1'b1;
        step(3);
        btn[2] = 1'b0;
        step(12);
        check_val("glitch_mode", int'(mode), 0);

        // Held press: mode changes exactly at edge 8
        btn[2] = 1'b1;
        step(7);
        check_val("hold_e7_mode", int'(mode), 0);
        step(1);
        check_val("hold_e8_mode",   int'(mode),        2);
        check_val("hold_e8_strobe", int'(mode_strobe), 1);
        step(1);
        check_val("hold_e9_strobe", int'(mode_strobe), 0);
        step(1);
        btn[2] = 1'b0;
        step(10);

        // Simultaneous presses: lowest index wins
        btn[3] = 1'b1;
        btn[1] = 1'b1;
        step(8);
        check_val("arb_mode", int'(mode), 1);
        step(2);
        btn[3] = 1'b0;
        btn[1] = 1'b0;
        step(10);

        // Re-press of the current mode gives no strobe
        btn[1] = 1'b1;
        step(8);
        check_val("repress_mode",   int'(mode),        1);
        check_val("repress_strobe", int'(mode_strobe), 0);
        step(2);
        btn[1] = 1'b0;
        step(10);

        // Demo wrap from mode 2: 3 -> 0 -> 1 at 20-cycle spacing
        press_btn(2);
        check_val("pre_demo_mode", int'(mode), 2);
        btn_demo = 1'b1;
        step(6);
        btn_demo = 1'b0;
        step(2);
        check_val("demo_on",      int'(demo_active), 1);
        check_val("demo_on_mode", int'(mode),        2);
        step(19);
        check_val("demo_e27_mode", int'(mode), 2);
        step(1);
        check_val("demo_adv1_mode",   int'(mode),        3);
        check_val("demo_adv1_strobe", int'(mode_strobe), 1);
        step(1);
        check_val("demo_adv1_strobe_end", int'(mode_strobe), 0);
        step(19);
        check_val("demo_adv2_mode", int'(mode), 0);
        step(20);
        check_val("demo_adv3_mode", int'(mode), 1);

        // Mode press landing on the same edge as timer expiry
        step(12);
        btn[0] = 1'b1;
        step(8);
        check_val("cancel_mode",   int'(mode),        0);
        check_val("cancel_demo",   int'(demo_active), 0);
        check_val("cancel_strobe", int'(mode_strobe), 1);
        step(2);
        btn[0] = 1'b0;
        step(30);
        check_val("cancel_hold_mode", int'(mode), 0);

        // Demo press and mode press on the same edge
        btn_demo = 1'b1;
        step(6);
        btn_demo = 1'b0;
        step(2);
        check_val("demo_on2", int'(demo_active), 1);
        step(6);
        btn_demo = 1'b1;
        btn[2]   = 1'b1;
        step(8);
        check_val("both_mode", int'(mode),        2);
        check_val("both_demo", int'(demo_active), 0);
        step(2);
        btn_demo = 1'b0;
        btn[2]   = 1'b0;
        step(12);

        // Reset in the middle of demo with btn[3] held through it
        btn_demo = 1'b1;
        step(6);
        btn_demo = 1'b0;
        step(6);
        check_val("demo_on3", int'(demo_active), 1);
        btn[3]  = 1'b1;
        reset_n = 1'b0;
        step(3);
        check_val("midrst_mode",   int'(mode),        0);
        check_val("midrst_demo",   int'(demo_active), 0);
        check_val("midrst_strobe", int'(mode_strobe), 0);
        reset_n = 1'b1;
        step(7);
        check_val("postrst_e7_mode", int'(mode), 0);
        step(1);
        check_val("postrst_e8_mode",   int'(mode),        3);
        check_val("postrst_e8_strobe", int'(mode_strobe), 1);
        btn[3] = 1'b0;
        step(12);

        // Random button activity with occasional resets
        rst_left = 0;
        for (int i = 0; i < 2500; i++) begin
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset_n  = 1'b0;
                rst_left = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b = $urandom_range(0, NB - 1);
                if (b < NM) btn[b] = ~btn[b];
                else        btn_demo = ~btn_demo;
            end
            step(1);
        end

        reset_n  = 1'b1;
        btn      = '0;
        btn_demo = 1'b0;
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
